// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core data-memory port. Accepts load/store
//   requests and performs byte/half/word accesses on a little-endian byte array
//   of 2**ADDR_W bytes. Loads answer after RD_LAT cycles; stores and rejected
//   requests answer after one cycle. Array contents survive reset.
//
// Handshake: a request (req_rd_i | req_wr_i) is accepted at a rising edge
//   when busy_o is 0. While busy_o is 1 requests are dropped, so the initiator
//   holds its request until busy_o is seen low. Every accepted request yields
//   exactly one rsp_valid_o pulse unless reset intervenes.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_rd_i     load request
//   req_wr_i     store request
//   req_addr_i   byte address
//   req_wdata_i  store data, LSB aligned
//   req_funct3_i RV32I load/store funct3
//   busy_o       1 = a request this cycle is ignored
//   rsp_valid_o  one-cycle response pulse
//   rsp_rdata_o  extended load data; 0 for stores and errors
//   rsp_err_o    request rejected (valid with rsp_valid_o)
//   state_o      FSM state for observation (0 IDLE, 1 WAIT, 2 RESP)
module dmem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_rd_i,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              busy_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // WAIT lasts RD_LAT-1 cycles; the counter runs down to zero.
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e            state_q;
  logic              busy_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [DATA_W-1:0] pend_q;
  logic [1:0]        cnt_q;

  logic [7:0] mem_q [0:(2**ADDR_W)-1];

  logic              accept;
  logic              req_err;
  logic              load_ok;
  logic              store_ok;
  logic [ADDR_W-3:0] word_idx;
  logic [7:0]        b0, b1, b2, b3;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_data;
  logic [3:0]        lane_we;
  logic [7:0]        lane_wd [4];

  assign accept   = (req_rd_i | req_wr_i) & ~busy_q;
  assign word_idx = req_addr_i[ADDR_W-1:2];

  // Request legality
  always_comb begin
    load_ok  = 1'b0;
    store_ok = 1'b0;
    case (req_funct3_i)
      3'b000, 3'b001, 3'b010: begin load_ok = 1'b1; store_ok = 1'b1; end
      3'b100, 3'b101:         load_ok = 1'b1;
      default:                ;
    endcase
    req_err = (req_rd_i & req_wr_i)
            | (req_rd_i & ~load_ok)
            | (req_wr_i & ~store_ok)
            | ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
            | ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));
  end

  // Load path: read the whole aligned word, then pick and extend.
  assign b0 = mem_q[{word_idx, 2'd0}];
  assign b1 = mem_q[{word_idx, 2'd1}];
  assign b2 = mem_q[{word_idx, 2'd2}];
  assign b3 = mem_q[{word_idx, 2'd3}];

  always_comb begin
    case (req_addr_i[1:0])
      2'd0:    byte_v = b0;
      2'd1:    byte_v = b1;
      2'd2:    byte_v = b2;
      default: byte_v = b3;
    endcase
    half_v = req_addr_i[1] ? {b3, b2} : {b1, b0};
    case (req_funct3_i)
      3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_data = {{16{half_v[15]}}, half_v};
      3'b010:  load_data = {b3, b2, b1, b0};
      3'b100:  load_data = {24'd0, byte_v};
      3'b101:  load_data = {16'd0, half_v};
      default: load_data = '0;
    endcase
  end

  // Store path: lane enables and per-lane data.
  always_comb begin
    lane_we = 4'b0000;
    if (accept && req_wr_i && !req_err) begin
      case (req_funct3_i[1:0])
        2'b00:   lane_we = 4'b0001 << req_addr_i[1:0];
        2'b01:   lane_we = req_addr_i[1] ? 4'b1100 : 4'b0011;
        default: lane_we = 4'b1111;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      case (req_funct3_i[1:0])
        2'b00:   lane_wd[i] = req_wdata_i[7:0];
        2'b01:   lane_wd[i] = (i % 2 == 1) ? req_wdata_i[15:8] : req_wdata_i[7:0];
        default: lane_wd[i] = req_wdata_i[8*i +: 8];
      endcase
    end
  end

  // The array has no reset so committed stores survive a reset pulse.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem_q[{word_idx, 2'(i)}] <= lane_wd[i];
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pend_q      <= '0;
      cnt_q       <= 2'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            if (req_rd_i && !req_err && (RD_LAT > 1)) begin
              state_q <= WAIT;
              busy_q  <= 1'b1;
              cnt_q   <= WAIT_INIT;
              pend_q  <= load_data;
            end else begin
              state_q     <= RESP;
              busy_q      <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_err;
              rsp_rdata_q <= (req_rd_i && !req_err) ? load_data : '0;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= RESP;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= pend_q;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances with RD_LAT = 1, 3 and 4,
// each with its own request and reset wires (index 0, 1, 2).
module tb_dmem_responder;

  logic        clk;
  logic        rst_n [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [8:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [2:0]  f3    [3];
  logic        busy  [3];
  logic        vld   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic [1:0]  st    [3];

  int n_cmp = 0;
  int n_bad = 0;

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_rd_i(rd[0]), .req_wr_i(wr[0]),
    .req_addr_i(addr[0]), .req_wdata_i(wdata[0]), .req_funct3_i(f3[0]),
    .busy_o(busy[0]), .rsp_valid_o(vld[0]), .rsp_rdata_o(rdata[0]),
    .rsp_err_o(err[0]), .state_o(st[0]));

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) u_lat3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_rd_i(rd[1]), .req_wr_i(wr[1]),
    .req_addr_i(addr[1]), .req_wdata_i(wdata[1]), .req_funct3_i(f3[1]),
    .busy_o(busy[1]), .rsp_valid_o(vld[1]), .rsp_rdata_o(rdata[1]),
    .rsp_err_o(err[1]), .state_o(st[1]));

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LAT(4)) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n[2]), .req_rd_i(rd[2]), .req_wr_i(wr[2]),
    .req_addr_i(addr[2]), .req_wdata_i(wdata[2]), .req_funct3_i(f3[2]),
    .busy_o(busy[2]), .rsp_valid_o(vld[2]), .rsp_rdata_o(rdata[2]),
    .rsp_err_o(err[2]), .state_o(st[2]));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers
  task automatic drive(input int k, input logic r, input logic w, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; f3[k] = f;
  endtask

  task automatic clear(input int k);
    drive(k, 1'b0, 1'b0, 9'h000, 32'h0, 3'b000);
  endtask

  // One request held for a single edge, then wait (bounded) for its response.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic xact(input int k, input string tag, input logic r, input logic w,
                      input logic [8:0] a, input logic [31:0] d, input logic [2:0] f,
                      output logic [31:0] od, output logic oe, output int lat);
    bit got = 0;
    od = 32'hx; oe = 1'bx; lat = 0;
    drive(k, r, w, a, d, f);
    @(posedge clk); #1;
    clear(k);
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (vld[k] === 1'b1) begin
        got = 1; lat = i; od = rdata[k]; oe = err[k];
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no rsp_valid within 8 cycles", tag);
    end
    @(posedge clk); #1;
  endtask

  // Tests
  task automatic test_reset;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (busy[k] !== 1'b0) begin n_bad++; $display("FAIL rst_busy[%0d]: got %b want 0", k, busy[k]); end
      n_cmp++; if (vld[k] !== 1'b0) begin n_bad++; $display("FAIL rst_valid[%0d]: got %b want 0", k, vld[k]); end
      n_cmp++; if (rdata[k] !== 32'h0) begin n_bad++; $display("FAIL rst_rdata[%0d]: got %h want 0", k, rdata[k]); end
      n_cmp++; if (err[k] !== 1'b0) begin n_bad++; $display("FAIL rst_err[%0d]: got %b want 0", k, err[k]); end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (st[k] !== 2'd0 || vld[k] !== 1'b0) begin n_bad++; $display("FAIL post_rst[%0d]: got st=%0d vld=%b want st=0 vld=0", k, st[k], vld[k]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word;
    logic [31:0] d; logic e; int lat;
    xact(0, "sw_010", 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b0 || d !== 32'h0) begin n_bad++; $display("FAIL sw_010: got err=%b rdata=%h want err=0 rdata=0", e, d); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sw_lat: got %0d want 1", lat); end
    xact(0, "lw_010", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b0 || d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_010: got err=%b rdata=%h want err=0 rdata=deadbeef", e, d); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lw_lat1: got %0d want 1", lat); end
  endtask

  task automatic test_byte_half;
    logic [31:0] d; logic e; int lat;
    xact(0, "sb_013", 1'b0, 1'b1, 9'h013, 32'h00000080, 3'b000, d, e, lat);
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL sb_013: got err=%b want 0", e); end
    xact(0, "lb_013", 1'b1, 1'b0, 9'h013, 32'h0, 3'b000, d, e, lat);
    n_cmp++; if (d !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_013: got %h want ffffff80", d); end
    xact(0, "lbu_013", 1'b1, 1'b0, 9'h013, 32'h0, 3'b100, d, e, lat);
    n_cmp++; if (d !== 32'h00000080) begin n_bad++; $display("FAIL lbu_013: got %h want 00000080", d); end
    xact(0, "lw_after_sb", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (d !== 32'h80ADBEEF) begin n_bad++; $display("FAIL lw_after_sb: got %h want 80adbeef", d); end
    xact(0, "lh_012", 1'b1, 1'b0, 9'h012, 32'h0, 3'b001, d, e, lat);
    n_cmp++; if (d !== 32'hFFFF80AD) begin n_bad++; $display("FAIL lh_012: got %h want ffff80ad", d); end
    xact(0, "lhu_010", 1'b1, 1'b0, 9'h010, 32'h0, 3'b101, d, e, lat);
    n_cmp++; if (d !== 32'h0000BEEF) begin n_bad++; $display("FAIL lhu_010: got %h want 0000beef", d); end
    xact(0, "lb_011", 1'b1, 1'b0, 9'h011, 32'h0, 3'b000, d, e, lat);
    n_cmp++; if (d !== 32'hFFFFFFBE) begin n_bad++; $display("FAIL lb_011: got %h want ffffffbe", d); end
    xact(0, "sh_012", 1'b0, 1'b1, 9'h012, 32'hAAAA1234, 3'b001, d, e, lat);
    xact(0, "lw_after_sh", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (d !== 32'h1234BEEF) begin n_bad++; $display("FAIL lw_after_sh: got %h want 1234beef", d); end
  endtask

  task automatic test_errors;
    logic [31:0] d; logic e; int lat;
    xact(0, "lh_odd", 1'b1, 1'b0, 9'h011, 32'h0, 3'b001, d, e, lat);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL lh_odd: got err=%b rdata=%h want err=1 rdata=0", e, d); end
    xact(0, "rd_wr", 1'b1, 1'b1, 9'h010, 32'h00000000, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL rd_wr: got err=%b rdata=%h want err=1 rdata=0", e, d); end
    xact(0, "f3_011", 1'b1, 1'b0, 9'h010, 32'h0, 3'b011, d, e, lat);
    n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL f3_011: got err=%b rdata=%h want err=1 rdata=0", e, d); end
    xact(0, "lw_mis", 1'b1, 1'b0, 9'h012, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL lw_mis: got err=%b want 1", e); end
    xact(0, "sw_mis", 1'b0, 1'b1, 9'h011, 32'hFFFFFFFF, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL sw_mis: got err=%b want 1", e); end
    xact(0, "st_f3_100", 1'b0, 1'b1, 9'h010, 32'h55555555, 3'b100, d, e, lat);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL st_f3_100: got err=%b want 1", e); end
    xact(0, "sh_odd", 1'b0, 1'b1, 9'h013, 32'h0000FFFF, 3'b001, d, e, lat);
    n_cmp++; if (e !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL sh_odd: got err=%b lat=%0d want err=1 lat=1", e, lat); end
    xact(0, "mem_kept", 1'b1, 1'b0, 9'h010, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b0 || d !== 32'h1234BEEF) begin n_bad++; $display("FAIL mem_kept: got err=%b rdata=%h want err=0 rdata=1234beef", e, d); end
  endtask

  task automatic test_latency3;
    logic [31:0] d; logic e; int lat; int extra;
    xact(1, "sw_020", 1'b0, 1'b1, 9'h020, 32'hCAFEF00D, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b0 || lat !== 1) begin n_bad++; $display("FAIL sw_020: got err=%b lat=%0d want err=0 lat=1", e, lat); end
    drive(1, 1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 9'h024, 32'h0, 3'b010);  // offered while busy: must be dropped
    @(negedge clk);
    n_cmp++; if (busy[1] !== 1'b1 || st[1] !== 2'd1 || vld[1] !== 1'b0) begin n_bad++; $display("FAIL lat3_c1: got busy=%b st=%0d vld=%b want 1 1 0", busy[1], st[1], vld[1]); end
    @(posedge clk); #1;
    clear(1);
    @(negedge clk);
    n_cmp++; if (busy[1] !== 1'b1 || vld[1] !== 1'b0) begin n_bad++; $display("FAIL lat3_c2: got busy=%b vld=%b want 1 0", busy[1], vld[1]); end
    @(negedge clk);
    n_cmp++; if (vld[1] !== 1'b1 || busy[1] !== 1'b0 || rdata[1] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL lat3_c3: got vld=%b busy=%b rdata=%h want 1 0 cafef00d", vld[1], busy[1], rdata[1]); end
    extra = 0;
    repeat (5) begin @(negedge clk); if (vld[1] !== 1'b0) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_drop: got %0d extra responses want 0", extra); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    drive(0, 1'b0, 1'b1, 9'h030, 32'h5A5AA5A5, 3'b010);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 9'h030, 32'h0, 3'b010);
    @(negedge clk);
    n_cmp++; if (vld[0] !== 1'b1 || err[0] !== 1'b0 || busy[0] !== 1'b0 || rdata[0] !== 32'h0) begin n_bad++; $display("FAIL b2b_sw: got vld=%b err=%b busy=%b rdata=%h want 1 0 0 0", vld[0], err[0], busy[0], rdata[0]); end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    @(negedge clk);
    n_cmp++; if (vld[0] !== 1'b1 || busy[0] !== 1'b0 || rdata[0] !== 32'h5A5AA5A5) begin n_bad++; $display("FAIL b2b_lw1: got vld=%b busy=%b rdata=%h want 1 0 5a5aa5a5", vld[0], busy[0], rdata[0]); end
    @(posedge clk); #1;
    clear(0);
    @(negedge clk);
    n_cmp++; if (vld[0] !== 1'b1 || rdata[0] !== 32'h1234BEEF) begin n_bad++; $display("FAIL b2b_lw2: got vld=%b rdata=%h want 1 1234beef", vld[0], rdata[0]); end
    @(negedge clk);
    n_cmp++; if (vld[0] !== 1'b0 || st[0] !== 2'd0) begin n_bad++; $display("FAIL b2b_end: got vld=%b st=%0d want 0 0", vld[0], st[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; logic e; int lat; int extra;
    xact(2, "sw_040", 1'b0, 1'b1, 9'h040, 32'h0BADC0DE, 3'b010, d, e, lat);
    n_cmp++; if (e !== 1'b0 || lat !== 1) begin n_bad++; $display("FAIL sw_040: got err=%b lat=%0d want err=0 lat=1", e, lat); end
    drive(2, 1'b1, 1'b0, 9'h040, 32'h0, 3'b010);
    @(posedge clk); #1;
    clear(2);
    @(negedge clk);
    n_cmp++; if (busy[2] !== 1'b1 || st[2] !== 2'd1) begin n_bad++; $display("FAIL lat4_wait: got busy=%b st=%0d want 1 1", busy[2], st[2]); end
    rst_n[2] = 1'b0;
    #1;
    n_cmp++; if (busy[2] !== 1'b0 || vld[2] !== 1'b0 || st[2] !== 2'd0) begin n_bad++; $display("FAIL async_rst: got busy=%b vld=%b st=%0d want 0 0 0", busy[2], vld[2], st[2]); end
    repeat (2) @(posedge clk);
    #1 rst_n[2] = 1'b1;
    extra = 0;
    repeat (6) begin @(negedge clk); if (vld[2] !== 1'b0) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL abort_rsp: got %0d responses want 0", extra); end
    @(posedge clk); #1;
    xact(2, "lw_040", 1'b1, 1'b0, 9'h040, 32'h0, 3'b010, d, e, lat);
    n_cmp++; if (d !== 32'h0BADC0DE || e !== 1'b0) begin n_bad++; $display("FAIL lw_040: got rdata=%h err=%b want 0badc0de 0", d, e); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL lat4: got %0d want 4", lat); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) clear(k);
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_latency3();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
